mem_bus_arbiter: RTL and testbench

//   Shares the single-port MAR-based program/data memory between two requesters: port 0 (CPU) and port 1 (loader/DMA).
//   Per access, sequences the memory's two-step protocol: load MAR with addr_en, then write with in_en or read with out_en.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 19 +
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory bus arbiter.
// State encodings are kept as plain constants alongside the enum for legacy code.
package mem_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_MEM_SIZE   = 256;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      ADDR = ST_ADDR,
      DATA = ST_DATA,
      ERR  = ST_ERR
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, favouring the port not granted last.
// Purely combinational; the last-grant register lives in the caller.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares a single-port MAR-based memory between two requesters and sequences
// the load-MAR / write-or-read protocol for each access.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0_valid,
   output logic                  p0_ready,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic                  p1_valid,
   output logic                  p1_ready,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_port,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  mem_addr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_in_en,
   output logic [DATA_WIDTH-1:0] mem_in,
   output logic                  mem_out_en,
   input  logic [DATA_WIDTH-1:0] mem_out
);

   arb_state_e            state;
   arb_state_e            state_nxt;
   logic                  last_grant;
   logic [1:0]            req;
   logic [1:0]            gnt;
   logic                  idle;
   logic                  accept;
   logic                  sel_port;
   logic                  sel_we;
   logic                  sel_legal;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  lat_we;
   logic                  lat_port;
   logic                  done;

   assign req = {p1_valid, p0_valid};

   rr_arbiter2 u_rr (
      .req        (req),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   assign idle      = (state == IDLE) && rst_n;
   assign accept    = idle && (gnt != 2'b00);
   assign sel_port  = gnt[1];
   assign sel_we    = sel_port ? p1_we    : p0_we;
   assign sel_addr  = sel_port ? p1_addr  : p0_addr;
   assign sel_wdata = sel_port ? p1_wdata : p0_wdata;
   assign sel_legal = sel_addr < ADDR_WIDTH'(MEM_SIZE);

   // A port that is valid but loses arbitration sees ready low, so
   // valid && ready always means this port was the one accepted.
   assign p0_ready = idle && !(p0_valid && !gnt[0]);
   assign p1_ready = idle && !(p1_valid && !gnt[1]);

   assign mem_addr_en = (state == ADDR);
   assign mem_in_en   = (state == DATA) && lat_we;
   assign mem_out_en  = (state == DATA) && !lat_we;
   assign done        = (state == DATA) || (state == ERR);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = sel_legal ? ADDR : ERR;
         ADDR:    state_nxt = DATA;
         DATA:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_addr / mem_in are loaded at accept so they hold steady through
   // ADDR and DATA and keep their last value outside those phases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lat_we     <= 1'b0;
         lat_port   <= 1'b0;
         mem_addr   <= '0;
         mem_in     <= '0;
         rsp_valid  <= 1'b0;
         rsp_port   <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            lat_we     <= sel_we;
            lat_port   <= sel_port;
            last_grant <= sel_port;
            if (sel_legal) begin
               mem_addr <= sel_addr;
               if (sel_we) mem_in <= sel_wdata;
            end
         end
         rsp_valid <= done;
         rsp_port  <= done ? lat_port : 1'b0;
         rsp_err   <= (state == ERR);
         rsp_rdata <= ((state == DATA) && !lat_we) ? mem_out : '0;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a behavioural
// MAR-based memory model attached to the mem_* pins.
module tb_mem_bus_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int MS = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          p0_valid, p0_ready, p0_we;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata;
   logic          p1_valid, p1_ready, p1_we;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata;
   logic          rsp_valid, rsp_port, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          mem_addr_en, mem_in_en, mem_out_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_in, mem_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mem_addr_en(mem_addr_en), .mem_addr(mem_addr), .mem_in_en(mem_in_en), .mem_in(mem_in),
      .mem_out_en(mem_out_en), .mem_out(mem_out)
   );

   // Memory model: MAR loads on addr_en, write at MAR on in_en, out = mem[MAR].
   logic [DW-1:0] mem [0:MS-1];
   logic [AW-1:0] mar;
   bit            model_init = 1'b0;
   int            en_cnt = 0;
   int            clash_cnt = 0;

   always @(posedge clk) begin
      if (!model_init) begin
         for (int i = 0; i < MS; i++) mem[i] = '0;
         mem[1]     = 16'h1111;
         mem[2]     = 16'h2222;
         mem[8'h20] = 16'h1234;
         mem[8'hFF] = 16'hA5A5;
         mar        = '0;
         model_init = 1'b1;
      end
      if (mem_addr_en || mem_in_en || mem_out_en) en_cnt++;
      if (mem_addr_en && mem_in_en) clash_cnt++;
      if (mem_addr_en) mar = mem_addr;
      if (mem_in_en) mem[mar[7:0]] = mem_in;
   end

   assign mem_out = mem[mar[7:0]];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL rst_p0_ready_in_reset got %0h exp 0", p0_ready); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL rst_p0_ready got %0h exp 1", p0_ready); end
      checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL rst_p1_ready got %0h exp 1", p1_ready); end
      checks++; if ({rsp_valid, rsp_port, rsp_err} !== 3'b000) begin errors++; $display("FAIL rst_rsp got %b exp 000", {rsp_valid, rsp_port, rsp_err}); end
      checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h exp 0000", rsp_rdata); end
      checks++; if ({mem_addr_en, mem_in_en, mem_out_en} !== 3'b000) begin errors++; $display("FAIL rst_mem_en got %b exp 000", {mem_addr_en, mem_in_en, mem_out_en}); end
      checks++; if ({mem_addr, mem_in} !== 32'h0) begin errors++; $display("FAIL rst_mem_bus got %h exp 0", {mem_addr, mem_in}); end
   endtask

   task automatic test_write_read();
      cyc();
      p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 16'hBEEF;
      @(negedge clk);
      checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL wr_accept_ready got %0h exp 1", p0_ready); end
      cyc();
      p0_valid = 1'b0; p0_we = 1'b0;
      @(negedge clk);
      checks++; if ({mem_addr_en, mem_in_en, mem_out_en} !== 3'b100) begin errors++; $display("FAIL wr_t1_en got %b exp 100", {mem_addr_en, mem_in_en, mem_out_en}); end
      checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL wr_t1_addr got %h exp 0010", mem_addr); end
      checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL wr_t1_ready got %0h exp 0", p0_ready); end
      cyc();
      @(negedge clk);
      checks++; if ({mem_addr_en, mem_in_en, mem_out_en} !== 3'b010) begin errors++; $display("FAIL wr_t2_en got %b exp 010", {mem_addr_en, mem_in_en, mem_out_en}); end
      checks++; if (mem_in !== 16'hBEEF) begin errors++; $display("FAIL wr_t2_data got %h exp BEEF", mem_in); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_t2_rsp got %0h exp 0", rsp_valid); end
      cyc();
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_port, rsp_err} !== 3'b100) begin errors++; $display("FAIL wr_t3_rsp got %b exp 100", {rsp_valid, rsp_port, rsp_err}); end
      checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL wr_t3_rdata got %h exp 0000", rsp_rdata); end
      checks++; if (mem[16] !== 16'hBEEF) begin errors++; $display("FAIL wr_mem got %h exp BEEF", mem[16]); end
      cyc();
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
      cyc();
      p0_valid = 1'b0;
      cyc();
      @(negedge clk);
      checks++; if ({mem_addr_en, mem_in_en, mem_out_en} !== 3'b001) begin errors++; $display("FAIL rd_t2_en got %b exp 001", {mem_addr_en, mem_in_en, mem_out_en}); end
      cyc();
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_port, rsp_err} !== 3'b100) begin errors++; $display("FAIL rd_t3_rsp got %b exp 100", {rsp_valid, rsp_port, rsp_err}); end
      checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_t3_rdata got %h exp BEEF", rsp_rdata); end
   endtask

   task automatic test_round_robin();
      logic          exp_p0;
      logic          exp_port;
      logic [DW-1:0] exp_data;
      // Fresh reset so the first contested grant goes to port 0.
      cyc(); rst_n = 1'b0;
      cyc(); rst_n = 1'b1;
      cyc();
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 16'h0001;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 16'h0002;
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         if (k % 3 == 0) begin
            exp_p0 = ((k / 3) % 2 == 0);
            checks++; if ({p0_ready, p1_ready} !== {exp_p0, !exp_p0}) begin errors++; $display("FAIL rr_grant_k%0d got %b exp %b", k, {p0_ready, p1_ready}, {exp_p0, !exp_p0}); end
         end
         if (k > 0 && k % 3 == 0) begin
            exp_port = (((k / 3) - 1) % 2 == 1);
            exp_data = exp_port ? 16'h2222 : 16'h1111;
            checks++; if ({rsp_valid, rsp_port, rsp_err} !== {1'b1, exp_port, 1'b0}) begin errors++; $display("FAIL rr_rsp_k%0d got %b exp %b", k, {rsp_valid, rsp_port, rsp_err}, {1'b1, exp_port, 1'b0}); end
            checks++; if (rsp_rdata !== exp_data) begin errors++; $display("FAIL rr_rdata_k%0d got %h exp %h", k, rsp_rdata, exp_data); end
         end else begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_k%0d got %0h exp 0", k, rsp_valid); end
         end
         if (k == 12) begin
            p0_valid = 1'b0; p1_valid = 1'b0;
         end else begin
            cyc();
         end
      end
   endtask

   task automatic test_error();
      int en_before;
      cyc();
      en_before = en_cnt;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 16'h0100;
      @(negedge clk);
      checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %0h exp 1", p1_ready); end
      cyc();
      p1_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_t1_rsp got %0h exp 0", rsp_valid); end
      cyc();
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_port, rsp_err} !== 3'b111) begin errors++; $display("FAIL err_t2_rsp got %b exp 111", {rsp_valid, rsp_port, rsp_err}); end
      checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL err_t2_rdata got %h exp 0000", rsp_rdata); end
      checks++; if (mem_addr !== 16'h0002) begin errors++; $display("FAIL err_addr_hold got %h exp 0002", mem_addr); end
      cyc();
      @(negedge clk);
      checks++; if (en_cnt !== en_before) begin errors++; $display("FAIL err_no_mem_en got %0d exp %0d", en_cnt, en_before); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %0h exp 0", rsp_valid); end
   endtask

   task automatic test_reset_mid_write();
      cyc();
      p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 16'h0020; p0_wdata = 16'h5678;
      cyc();
      p0_valid = 1'b0; p0_we = 1'b0;
      cyc();
      checks++; if (mem_in_en !== 1'b1) begin errors++; $display("FAIL rstmid_in_en_before got %0h exp 1", mem_in_en); end
      rst_n = 1'b0;
      #1;
      checks++; if ({mem_addr_en, mem_in_en, mem_out_en} !== 3'b000) begin errors++; $display("FAIL rstmid_en_drop got %b exp 000", {mem_addr_en, mem_in_en, mem_out_en}); end
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp_%0d got %0h exp 0", k, rsp_valid); end
         cyc();
      end
      @(negedge clk);
      checks++; if (mem[32] !== 16'h1234) begin errors++; $display("FAIL rstmid_mem got %h exp 1234", mem[32]); end
      checks++; if ({p0_ready, p1_ready} !== 2'b11) begin errors++; $display("FAIL rstmid_idle got %b exp 11", {p0_ready, p1_ready}); end
   endtask

   task automatic test_last_word();
      cyc();
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 16'h00FF;
      cyc();
      p1_valid = 1'b0;
      @(negedge clk);
      checks++; if ({mem_addr_en, mem_addr} !== {1'b1, 16'h00FF}) begin errors++; $display("FAIL last_addr got %b/%h exp 1/00FF", mem_addr_en, mem_addr); end
      cyc();
      cyc();
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_port, rsp_err} !== 3'b110) begin errors++; $display("FAIL last_rsp got %b exp 110", {rsp_valid, rsp_port, rsp_err}); end
      checks++; if (rsp_rdata !== 16'hA5A5) begin errors++; $display("FAIL last_rdata got %h exp A5A5", rsp_rdata); end
      checks++; if (clash_cnt !== 0) begin errors++; $display("FAIL en_clash got %0d exp 0", clash_cnt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_error();
      test_reset_mid_write();
      test_last_word();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
